// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage and the host port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // Byte-select encoding: 00 byte, 01 half, 10 word.
    localparam logic [1:0] BYTESEL_WORD = 2'b10;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of blocked host cycles; flags when the host has waited STARVE_LIMIT cycles.
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign limit = (count == CNT_W'(STARVE_LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has priority, host uses idle cycles.
// Optional starvation guard (forced one-cycle stall) enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CPU_MemRead,
    input  logic              CPU_MemWrite,
    input  logic [ADDR_W-1:0] CPU_Address,
    input  logic [DATA_W-1:0] CPU_WriteData,
    input  logic [1:0]        CPU_ByteSel,
    output logic [DATA_W-1:0] CPU_ReadData,
    output logic              Stall,
    input  logic              Host_Req,
    input  logic              Host_We,
    input  logic [ADDR_W-1:0] Host_Address,
    input  logic [DATA_W-1:0] Host_WriteData,
    output logic              Host_Ack,
    output logic [DATA_W-1:0] Host_ReadData,
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic [1:0]        Mem_ByteSel,
    input  logic [DATA_W-1:0] Mem_ReadData
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be within 1..15");
    end

    arb_state_t state, next_state;
    logic       cpu_busy;
    logic       host_grant;
    logic       starve_hit;
    logic       unused_addr_lsb;

    assign cpu_busy        = CPU_MemRead | CPU_MemWrite;
    assign unused_addr_lsb = ^Host_Address[1:0];

`ifdef DMEM_ARB_STARVE_EN
    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk  (Clock),
        .rst  (Reset),
        .clr  (next_state != PEND),
        .inc  ((state == PEND) && cpu_busy && Host_Req),
        .limit(starve_hit)
    );
    assign Stall = (state == FORCE);
`else
    assign starve_hit = 1'b0;
    assign Stall      = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A dropped request beats a grant; an active CPU beats the host unless the guard fires.
    always_comb begin
        next_state = state;
        host_grant = 1'b0;
        case (state)
            IDLE: begin
                if (Host_Req) next_state = PEND;
            end
            PEND: begin
                if (!Host_Req) begin
                    next_state = IDLE;
                end else if (!cpu_busy) begin
                    next_state = ACK;
                    host_grant = 1'b1;
                end else if (starve_hit) begin
                    next_state = FORCE;
                end
            end
            FORCE: begin
                next_state = ACK;
                host_grant = 1'b1;
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        Mem_Read      = CPU_MemRead;
        Mem_Write     = CPU_MemWrite;
        Mem_Address   = CPU_Address;
        Mem_WriteData = CPU_WriteData;
        Mem_ByteSel   = CPU_ByteSel;
        CPU_ReadData  = Mem_ReadData;
        if (host_grant) begin
            Mem_Read      = ~Host_We;
            Mem_Write     = Host_We;
            Mem_Address   = {Host_Address[ADDR_W-1:2], 2'b00};
            Mem_WriteData = Host_WriteData;
            Mem_ByteSel   = BYTESEL_WORD;
            CPU_ReadData  = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Host_Ack      <= 1'b0;
            Host_ReadData <= '0;
        end else begin
            Host_Ack <= (next_state == ACK);
            if (host_grant && !Host_We) begin
                Host_ReadData <= Mem_ReadData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a scoreboard of expected host completions.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_bsel;
    logic        stall;
    logic        host_req, host_we, host_ack;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_bsel;

    logic [31:0] mem [0:63];

    typedef struct {
        logic [31:0] data;
        logic        is_read;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_LIMIT(LIM),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .Clock(clk), .Reset(rst),
        .CPU_MemRead(cpu_rd), .CPU_MemWrite(cpu_wr), .CPU_Address(cpu_addr),
        .CPU_WriteData(cpu_wdata), .CPU_ByteSel(cpu_bsel), .CPU_ReadData(cpu_rdata),
        .Stall(stall),
        .Host_Req(host_req), .Host_We(host_we), .Host_Address(host_addr),
        .Host_WriteData(host_wdata), .Host_Ack(host_ack), .Host_ReadData(host_rdata),
        .Mem_Read(mem_rd), .Mem_Write(mem_wr), .Mem_Address(mem_addr),
        .Mem_WriteData(mem_wdata), .Mem_ByteSel(mem_bsel), .Mem_ReadData(mem_rdata)
    );

    function automatic logic [31:0] mem_init_val(int i);
        return (i == 4) ? 32'hDEAD_BEEF : {16'hC0DE, 16'(i)};
    endfunction

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= mem_init_val(i);
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 32'h0000_00F0; cpu_wdata = 0; cpu_bsel = 2'b00;
    endtask

    task automatic pop_and_check(string name);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty at Host_Ack", name);
        end else begin
            e = sb.pop_front();
            if (e.is_read && host_rdata !== e.data) begin
                errors++;
                $display("FAIL %s Host_ReadData got %h want %h", name, host_rdata, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; cpu_idle();
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        #2;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", host_ack); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", host_rdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // cycle 0: CPU busy, host asks for a read of 0x14
        next_cycle();
        cpu_rd = 1; cpu_addr = 32'h40; host_req = 1; host_we = 0; host_addr = 32'h14;
        next_cycle();
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL rst_pend_cpu got %h want 40", mem_addr); end
        rst = 1; cpu_rd = 0;
        #1;
        checks++; if (mem_rd !== 1'b0 || mem_addr !== 32'h40) begin
            errors++; $display("FAIL rst_abort got rd=%b addr=%h want rd=0 addr=40", mem_rd, mem_addr);
        end
        checks++; if (host_ack !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_async_out got ack=%b stall=%b want 0 0", host_ack, stall);
        end
        next_cycle();
        rst = 0;
        sb.push_back('{mem_init_val(5), 1'b1});
        #1;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_release_idle got %b want 0", mem_rd); end
        next_cycle();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h14) begin
            errors++; $display("FAIL rst_repend got rd=%b addr=%h want 1 14", mem_rd, mem_addr);
        end
        next_cycle();
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rst_ack_after got %b want 1", host_ack); end
        pop_and_check("rst_read");
        host_req = 0;
        next_cycle();
    endtask

    task automatic test_idle_read();
        cpu_idle();
        host_req = 1; host_we = 0; host_addr = 32'h10;
        sb.push_back('{32'hDEAD_BEEF, 1'b1});
        #1;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rd_c0 Mem_Read got %b want 0", mem_rd); end
        next_cycle();
        checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h10 || mem_bsel !== BYTESEL_WORD) begin
            errors++; $display("FAIL rd_c1 got rd=%b wr=%b addr=%h bsel=%b want 1 0 10 %b",
                               mem_rd, mem_wr, mem_addr, mem_bsel, BYTESEL_WORD);
        end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rd_c1_ack got %b want 0", host_ack); end
        next_cycle();
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rd_c2_ack got %b want 1", host_ack); end
        pop_and_check("rd_data");
        host_req = 0;
        next_cycle();
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rd_c3_ack got %b want 0", host_ack); end
    endtask

`ifdef DMEM_ARB_STARVE_EN
    task automatic test_busy_guard();
        logic [31:0] a;
        cpu_idle();
        cpu_rd = 1; cpu_addr = 32'h80;
        host_req = 1; host_we = 1; host_addr = 32'h20; host_wdata = 32'h1234_5678;
        sb.push_back('{32'h1234_5678, 1'b0});
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            a = (c == 6) ? 32'h80 + 32'd20 : 32'h80 + 32'(4 * c);
            cpu_addr = a;
            #1;
            checks++; if (stall !== (c == 5)) begin
                errors++; $display("FAIL guard_stall c%0d got %b want %b", c, stall, (c == 5));
            end
            if (c == 5) begin
                checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h20 ||
                              mem_wdata !== 32'h1234_5678 || cpu_rdata !== 32'h0) begin
                    errors++; $display("FAIL guard_force got wr=%b rd=%b addr=%h wd=%h crd=%h",
                                       mem_wr, mem_rd, mem_addr, mem_wdata, cpu_rdata);
                end
            end else begin
                checks++; if (mem_rd !== 1'b1 || mem_addr !== a || cpu_rdata !== mem_init_val(int'(a[7:2]))) begin
                    errors++; $display("FAIL guard_cpu c%0d got rd=%b addr=%h crd=%h want 1 %h %h",
                                       c, mem_rd, mem_addr, cpu_rdata, a, mem_init_val(int'(a[7:2])));
                end
            end
            checks++; if (host_ack !== (c == 6)) begin
                errors++; $display("FAIL guard_ack c%0d got %b want %b", c, host_ack, (c == 6));
            end
            if (c == 6) pop_and_check("guard_write");
        end
        host_req = 0;
        next_cycle();
        cpu_idle();
        #1;
        checks++; if (mem[8] !== 32'h1234_5678) begin errors++; $display("FAIL guard_memword got %h want 12345678", mem[8]); end
    endtask
`else
    task automatic test_busy_noguard();
        cpu_idle();
        cpu_rd = 1; cpu_addr = 32'h80;
        host_req = 1; host_we = 1; host_addr = 32'h20; host_wdata = 32'h1234_5678;
        sb.push_back('{32'h1234_5678, 1'b0});
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            cpu_addr = 32'h80 + 32'(4 * (c % 8));
            #1;
            checks++; if (stall !== 1'b0 || host_ack !== 1'b0 || mem_addr !== cpu_addr || mem_wr !== 1'b0) begin
                errors++; $display("FAIL noguard_busy c%0d got stall=%b ack=%b addr=%h wr=%b",
                                   c, stall, host_ack, mem_addr, mem_wr);
            end
        end
        next_cycle();
        cpu_idle();
        #1;
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL noguard_grant got wr=%b addr=%h wd=%h", mem_wr, mem_addr, mem_wdata);
        end
        next_cycle();
        checks++; if (host_ack !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL noguard_ack got ack=%b stall=%b want 1 0", host_ack, stall);
        end
        if (host_ack === 1'b1) pop_and_check("noguard_write");
        host_req = 0;
        next_cycle();
        checks++; if (mem[8] !== 32'h1234_5678) begin errors++; $display("FAIL noguard_memword got %h want 12345678", mem[8]); end
    endtask
`endif

    task automatic test_abort_misalign();
        int acks = 0;
        int strobes = 0;
        cpu_idle();
        cpu_rd = 1; cpu_addr = 32'h84;
        host_req = 1; host_we = 1; host_addr = 32'h30; host_wdata = 32'hBAD0_BAD0;
        next_cycle();
        next_cycle();
        host_req = 0; cpu_idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mem_rd === 1'b1 || mem_wr === 1'b1) strobes++;
            if (host_ack === 1'b1) acks++;
            next_cycle();
        end
        checks++; if (strobes != 0 || acks != 0) begin
            errors++; $display("FAIL abort got strobes=%0d acks=%0d want 0 0", strobes, acks);
        end
        checks++; if (mem[12] !== mem_init_val(12)) begin
            errors++; $display("FAIL abort_mem got %h want %h", mem[12], mem_init_val(12));
        end
        host_req = 1; host_we = 0; host_addr = 32'h23;
        sb.push_back('{32'h1234_5678, 1'b1});
        next_cycle();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h20 || mem_bsel !== BYTESEL_WORD) begin
            errors++; $display("FAIL misalign got rd=%b addr=%h bsel=%b want 1 20 %b", mem_rd, mem_addr, mem_bsel, BYTESEL_WORD);
        end
        next_cycle();
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL misalign_ack got %b want 1", host_ack); end
        pop_and_check("misalign_read");
        host_req = 0;
        next_cycle();
    endtask

    task automatic test_passthrough();
        cpu_idle();
        cpu_wr = 1; cpu_addr = 32'h44; cpu_wdata = 32'hA5A5_0F0F; cpu_bsel = 2'b01;
        #1;
        checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h44 ||
                      mem_wdata !== 32'hA5A5_0F0F || mem_bsel !== 2'b01) begin
            errors++; $display("FAIL pass_store got wr=%b rd=%b addr=%h wd=%h bsel=%b",
                               mem_wr, mem_rd, mem_addr, mem_wdata, mem_bsel);
        end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL pass_ack got %b want 0", host_ack); end
        next_cycle();
        cpu_wr = 0; cpu_rd = 1; cpu_bsel = 2'b00;
        #1;
        checks++; if (cpu_rdata !== 32'hA5A5_0F0F || mem_bsel !== 2'b00) begin
            errors++; $display("FAIL pass_load got %h bsel=%b want a5a50f0f 00", cpu_rdata, mem_bsel);
        end
        next_cycle();
        cpu_idle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_idle_read();
`ifdef DMEM_ARB_STARVE_EN
        test_busy_guard();
`else
        test_busy_noguard();
`endif
        test_abort_misalign();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipelined CPU's MEM stage and a host/debug port used for memory inspection and loading. The CPU has priority, and the host uses idle memory cycles. An optional starvation guard forces a one-cycle pipeline stall so a waiting host request is serviced. The block sits between the EXMEM register outputs and the data memory, and its Stall output feeds the pipeline write enables.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive blocked host cycles before a forced grant (range 1..15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- CPU_MemRead, CPU_MemWrite  in  1  MEM-stage access strobes.
- CPU_Address  in  ADDR_W  MEM-stage address.
- CPU_WriteData  in  DATA_W  store data.
- CPU_ByteSel  in  2  byte/half/word select, passed through.
- CPU_ReadData  out  DATA_W  memory read data routed to the CPU.
- Stall  out  1  freeze the PC, IFID, IDEX and EXMEM registers for this cycle.
- Host_Req  in  1  level request; address, data and We are held stable until Host_Ack.
- Host_We  in  1  1 = write, 0 = read.
- Host_Address  in  ADDR_W  word address; bits [1:0] are forced to 0.
- Host_WriteData  in  DATA_W  write data.
- Host_Ack  out  1  one-cycle completion pulse.
- Host_ReadData  out  DATA_W  registered read data, valid from the Host_Ack cycle and held until the next host read.
- Mem_Read, Mem_Write  out  1  memory strobes.
- Mem_Address  out  ADDR_W  memory address.
- Mem_WriteData  out  DATA_W  memory write data.
- Mem_ByteSel  out  2  memory byte select.
- Mem_ReadData  in  DATA_W  combinational read data from memory.

## Operation
- FSM states: IDLE, PEND, FORCE, ACK.
- IDLE:
  - Host_Req=1 -> PEND.
  - Otherwise stay in IDLE.
- PEND, CPU idle (CPU_MemRead=CPU_MemWrite=0):
  - The host owns the memory this cycle.
  - Next state is ACK.
- PEND, CPU accessing:
  - The CPU owns the memory.
  - Wait_Cnt increments.
  - With STARVE_LIMIT reached (Wait_Cnt==STARVE_LIMIT-1), next state is FORCE.
- PEND, Host_Req dropped before a grant:
  - Next state is IDLE.
  - No memory access occurs and no Host_Ack is issued.
- FORCE:
  - Stall=1 and the host owns the memory.
  - CPU strobes are suppressed and CPU_ReadData=0; the pipeline replays the access next cycle.
  - The request is committed, so Host_Req is ignored.
  - Next state is ACK.
- ACK:
  - Host_Ack=1.
  - Host_Req is ignored this cycle, which prevents a double grant.
  - Next state is IDLE.
- Host-owned cycle:
  - Mem_Address={Host_Address[ADDR_W-1:2],2'b00}.
  - Mem_ByteSel=BYTESEL_WORD.
  - Mem_Write=Host_We, Mem_Read=~Host_We.
  - On a read, Mem_ReadData is captured into Host_ReadData at the closing edge.
- CPU-owned or idle cycle: Mem_* is a pass-through of CPU_* and CPU_ReadData=Mem_ReadData.
- Wait_Cnt clears whenever the FSM leaves PEND.

## Timing
- Reset values (asynchronous): state=IDLE, Wait_Cnt=0, Host_Ack=0, Host_ReadData=0, Stall=0.
- Mem_* and CPU_ReadData are combinational from state and inputs. Host_Ack and Host_ReadData are registered.
- Minimum host latency: Req at cycle 0 -> grant in cycle 1 -> Host_Ack in cycle 2.
- Worst case with the starvation guard: grant at cycle 1+STARVE_LIMIT, Ack at cycle 2+STARVE_LIMIT.
- A CPU access and a PEND grant decision in the same cycle always go to the CPU, except in FORCE.
- Stall is asserted for exactly one cycle per forced grant and never in any other state.
- Reset during PEND or FORCE aborts the request. The host must keep Req asserted; it re-enters PEND after reset.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - Wait_Cnt and the FORCE state are present.
  - STARVE_LIMIT is honoured.
- DMEM_ARB_STARVE_EN undefined:
  - No counter and no FORCE state; Stall is tied 0.
  - The host is served only in CPU-idle cycles and may wait indefinitely.
  - STARVE_LIMIT is ignored.

## Structure
- Shared package dmem_arb_pkg:
  - state enum (IDLE, PEND, FORCE, ACK);
  - BYTESEL_WORD constant;
  - counter width constant (4 bits).
- Sub-module arb_starve_counter holds the saturating wait counter with clear and increment and produces the limit flag. It is instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset behaviour: assert Reset mid-PEND -> all outputs return to their reset values immediately; after release with Req held, PEND follows one cycle later.
- Idle-CPU host read: CPU idle, Host_Req read at 0x0000_0010, memory word 0xDEADBEEF -> Mem_Read in cycle 1, Host_Ack in cycle 2, Host_ReadData=0xDEADBEEF.
- Busy CPU with guard: CPU accesses every cycle, STARVE_LIMIT=4, host write 0x1234_5678 to 0x20 -> Stall=1 only in cycle 5, memory write in cycle 5, Host_Ack in cycle 6; the CPU access of cycle 5 replays in cycle 6.
- Busy CPU without the guard: DMEM_ARB_STARVE_EN undefined, CPU busy 20 cycles -> no Ack and Stall=0 throughout; grant and Ack follow the first idle cycle.
- Abort and misalignment: Req dropped in PEND -> no Mem strobe and no Ack. Host_Address 0x23 -> Mem_Address 0x20 with ByteSel=BYTESEL_WORD.
- CPU pass-through: CPU store with ByteSel=01 during IDLE -> Mem_* equals CPU_* bit-exact; Host_Ack remains 0.
